// File: rtl/spi_pkg.sv
// spi_pkg: shared constants for the SPI shift engine (state encoding, defaults).
// Latency: n/a (package only).
// Backpressure: n/a.
package spi_pkg;

   // Default bits per transfer.
   localparam int DEFAULT_DATA_WIDTH = 8;

   // Smallest clk_i : SCLK ratio the engine is designed for.
   localparam int MIN_DIV_RATIO = 4;

   // One-hot state encoding of the shift engine.
   localparam int ST_W = 5;
   typedef enum logic [ST_W-1:0] {
      ST_IDLE  = 5'b00001,
      ST_SETUP = 5'b00010,
      ST_SHIFT = 5'b00100,
      ST_DRAIN = 5'b01000,
      ST_HOLD  = 5'b10000
   } state_e;

endpackage

// File: rtl/sclk_edge_detect.sv
// sclk_edge_detect: flags leading / trailing edges of the divided SCLK level.
// Latency: flags are registered, high for one cycle, one cycle after level_i changes.
// Backpressure: none; free-running on every clk_i cycle.
module sclk_edge_detect
   import spi_pkg::*;
#(
   parameter bit IDLE_HIGH = 1'b1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic level_i,
   output logic leading_o,
   output logic trailing_o
);

   logic level_q;
   logic leading_q;
   logic trailing_q;

   // Register the level once and compare against the previous sample.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         level_q    <= IDLE_HIGH;
         leading_q  <= 1'b0;
         trailing_q <= 1'b0;
      end else begin
         level_q    <= level_i;
         leading_q  <= (level_q == IDLE_HIGH) && (level_i != IDLE_HIGH);
         trailing_q <= (level_q != IDLE_HIGH) && (level_i == IDLE_HIGH);
      end
   end

   assign leading_o  = leading_q;
   assign trailing_o = trailing_q;

endmodule

// File: rtl/spi_shift.sv
// spi_shift: SPI master shift engine driven by an external SCLK divider.
// Latency: one word per transfer, ~DATA_WIDTH SCLK periods plus SETUP/DRAIN/HOLD cycles.
// Backpressure: ready_o only in IDLE; SPI_SHIFT_RX_EN enables the MISO receive path.
module spi_shift
   import spi_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter bit IDLE_HIGH  = 1'b1,
   parameter bit MSB_FIRST  = 1'b1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  sclk_i,
   output logic                  sclk_en_o,
   output logic                  cs_n_o,
   output logic                  mosi_o,
   input  logic                  miso_i,
   output logic                  rx_valid_o,
   output logic [DATA_WIDTH-1:0] rx_data_o,
   output logic                  busy_o
);

   localparam int CNT_W = $clog2(DATA_WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_LAST_SHIFT = CNT_W'(DATA_WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL       = CNT_W'(DATA_WIDTH);

   state_e state_q, state_d;

   logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
   logic [DATA_WIDTH-1:0] tx_q, tx_d;
   logic                  mosi_q, mosi_d;
   logic                  cs_n_q, cs_n_d;
   logic                  sclk_en_q, sclk_en_d;
   logic                  ready_q, ready_d;
   logic                  hold_q, hold_d;

   logic lead;
   logic trail;
   logic handshake;
   logic shifting;

   sclk_edge_detect #(
      .IDLE_HIGH (IDLE_HIGH)
   ) u_edge (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .level_i    (sclk_i),
      .leading_o  (lead),
      .trailing_o (trail)
   );

   assign handshake = valid_i && ready_q;
   assign shifting  = (state_q == ST_SHIFT) || (state_q == ST_DRAIN);
   // Counter saturates at a full word so it can never wrap mid-transfer.
   assign cnt_inc   = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + 1'b1;

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: the last SCLK period completes in DRAIN after the divider enable drops.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (handshake) state_d = ST_SETUP;
         ST_SETUP: state_d = ST_SHIFT;
         ST_SHIFT: if (trail && (cnt_inc == CNT_LAST_SHIFT)) state_d = ST_DRAIN;
         ST_DRAIN: if (trail && (cnt_inc == CNT_FULL)) state_d = ST_HOLD;
         ST_HOLD:  if (hold_q) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Output / datapath next-values; edges outside SHIFT and DRAIN are ignored.
   always_comb begin
      cnt_d     = cnt_q;
      tx_d      = tx_q;
      mosi_d    = mosi_q;
      cs_n_d    = cs_n_q;
      sclk_en_d = sclk_en_q;
      hold_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (handshake) begin
               tx_d   = data_i;
               mosi_d = MSB_FIRST ? data_i[DATA_WIDTH-1] : data_i[0];
               cs_n_d = 1'b0;
               cnt_d  = '0;
            end
         end
         ST_SETUP: begin
            sclk_en_d = 1'b1;
         end
         ST_SHIFT, ST_DRAIN: begin
            if (trail) begin
               cnt_d = cnt_inc;
            end
            // Bit 0 is already on the line, so the first leading edge (count 0) is skipped.
            if (lead && (cnt_q != '0)) begin
               if (MSB_FIRST) begin
                  tx_d   = {tx_q[DATA_WIDTH-2:0], 1'b0};
                  mosi_d = tx_q[DATA_WIDTH-2];
               end else begin
                  tx_d   = {1'b0, tx_q[DATA_WIDTH-1:1]};
                  mosi_d = tx_q[1];
               end
            end
            if ((state_q == ST_SHIFT) && trail && (cnt_inc == CNT_LAST_SHIFT)) begin
               sclk_en_d = 1'b0;
            end
         end
         ST_HOLD: begin
            hold_d = 1'b1;
            if (hold_q) begin
               cs_n_d = 1'b1;
            end
         end
         default: begin
            cs_n_d    = 1'b1;
            sclk_en_d = 1'b0;
         end
      endcase
      ready_d = (state_d == ST_IDLE);
   end

   // Datapath and output registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q     <= '0;
         tx_q      <= '0;
         mosi_q    <= 1'b0;
         cs_n_q    <= 1'b1;
         sclk_en_q <= 1'b0;
         ready_q   <= 1'b0;
         hold_q    <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         tx_q      <= tx_d;
         mosi_q    <= mosi_d;
         cs_n_q    <= cs_n_d;
         sclk_en_q <= sclk_en_d;
         ready_q   <= ready_d;
         hold_q    <= hold_d;
      end
   end

   assign ready_o   = ready_q;
   assign mosi_o    = mosi_q;
   assign cs_n_o    = cs_n_q;
   assign sclk_en_o = sclk_en_q;
   assign busy_o    = (state_q != ST_IDLE);

`ifdef SPI_SHIFT_RX_EN
   logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
   logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
   logic                  rx_valid_q, rx_valid_d;

   // Receive shift: sample MISO on each trailing edge, publish the word on the last one.
   always_comb begin
      rx_sh_d    = rx_sh_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      if (shifting && trail) begin
         rx_sh_d = MSB_FIRST ? {rx_sh_q[DATA_WIDTH-2:0], miso_i}
                             : {miso_i, rx_sh_q[DATA_WIDTH-1:1]};
         if ((state_q == ST_DRAIN) && (cnt_inc == CNT_FULL)) begin
            rx_data_d  = rx_sh_d;
            rx_valid_d = 1'b1;
         end
      end
   end

   // Receive registers; reset drops any partial word without a strobe.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rx_sh_q    <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
      end else begin
         rx_sh_q    <= rx_sh_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
      end
   end

   assign rx_data_o  = rx_data_q;
   assign rx_valid_o = rx_valid_q;
`else
   // Transmit-only build: MISO is not looked at and the receive outputs stay quiet.
   logic unused_rx;
   assign unused_rx  = miso_i ^ shifting;
   assign rx_data_o  = '0;
   assign rx_valid_o = 1'b0;
`endif

endmodule

// File: tb/tb_spi_shift.sv
// tb_spi_shift: directed checks of spi_shift with a ratio-8 SCLK divider model.
// Latency: n/a (testbench).
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_spi_shift;

`ifdef SPI_SHIFT_RX_EN
   localparam bit RX = 1'b1;
`else
   localparam bit RX = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       valid;
   logic [7:0] data;
   logic       loop_a;
   logic       miso_fix_a;

   logic [1:0] sclk = 2'b11;
   logic [1:0] en, cs_n, mosi, ready, busy, rxv, miso;
   logic [7:0] rxd_a, rxd_b;

   assign miso[0] = loop_a ? mosi[0] : miso_fix_a;
   assign miso[1] = 1'b1;

   spi_shift #(.DATA_WIDTH(8), .IDLE_HIGH(1'b1), .MSB_FIRST(1'b1)) u_dut_msb (
      .clk_i(clk), .rst_i(rst), .valid_i(valid), .ready_o(ready[0]), .data_i(data),
      .sclk_i(sclk[0]), .sclk_en_o(en[0]), .cs_n_o(cs_n[0]), .mosi_o(mosi[0]),
      .miso_i(miso[0]), .rx_valid_o(rxv[0]), .rx_data_o(rxd_a), .busy_o(busy[0]));

   spi_shift #(.DATA_WIDTH(8), .IDLE_HIGH(1'b1), .MSB_FIRST(1'b0)) u_dut_lsb (
      .clk_i(clk), .rst_i(rst), .valid_i(valid), .ready_o(ready[1]), .data_i(data),
      .sclk_i(sclk[1]), .sclk_en_o(en[1]), .cs_n_o(cs_n[1]), .mosi_o(mosi[1]),
      .miso_i(miso[1]), .rx_valid_o(rxv[1]), .rx_data_o(rxd_b), .busy_o(busy[1]));

   // Divider model (ratio 8, idle high) plus line monitor, one lane per DUT.
   // Once enabled it runs whole periods (idle half, then active half) and stops
   // only on a trailing edge seen with the enable low.
   logic [1:0] run = 2'b00;
   int         dcnt [2];
   int         leads [2];
   int         trails [2];
   int         rxv_cnt [2];
   int         tail_lo [2];
   int         rdy_bad [2];
   logic [7:0] bits [2] = '{8'h00, 8'h00};

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         logic trail_now;
         trail_now = 1'b0;
         if (!run[i]) begin
            dcnt[i] = 0;
            sclk[i] = 1'b1;
            if (en[i] === 1'b1) run[i] = 1'b1;
         end else if (dcnt[i] == 3) begin
            dcnt[i] = 0;
            sclk[i] = ~sclk[i];
            if (sclk[i] == 1'b0) begin
               leads[i]++;
            end else begin
               trail_now = 1'b1;
               trails[i]++;
               bits[i] = {bits[i][6:0], mosi[i]};
               if (en[i] !== 1'b1) run[i] = 1'b0;
            end
         end else begin
            dcnt[i]++;
         end
         if (trail_now) tail_lo[i] = 0;
         else if (cs_n[i] === 1'b0) tail_lo[i]++;
         if (rxv[i] === 1'b1) rxv_cnt[i]++;
         if (ready[i] === 1'b1 && (busy[i] === 1'b1 || cs_n[i] === 1'b0)) rdy_bad[i]++;
      end
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   task automatic start(input logic [7:0] d, input string tag);
      @(negedge clk);
      valid = 1'b1;
      data  = d;
      @(posedge clk);
      @(negedge clk);
      valid = 1'b0;
      data  = ~d;
      check_eq({tag, "_acc"}, 32'(busy[0]), 1);
   endtask

   task automatic wait_idle(input string tag);
      int k;
      k = 0;
      while (!(busy[0] === 1'b0 && busy[1] === 1'b0) && k < 400) begin
         @(negedge clk);
         k++;
      end
      check_eq({tag, "_done"}, 32'(k < 400), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, l0, r0, r1, b0, k, gap;
      rst        = 1'b1;
      valid      = 1'b0;
      data       = 8'h00;
      loop_a     = 1'b1;
      miso_fix_a = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_cs_n",    32'(cs_n[0]), 1);
      check_eq("rst_sclk_en", 32'(en[0]),   0);
      check_eq("rst_mosi",    32'(mosi[0]), 0);
      check_eq("rst_rxv",     32'(rxv[0]),  0);
      check_eq("rst_rxd",     32'(rxd_a),   0);
      check_eq("rst_busy",    32'(busy[0]), 0);
      check_eq("rst_ready",   32'(ready[0]), 0);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_eq("ready_after_rst", 32'(ready), 32'h3);

      // 0xA5 MSB first with MISO looped back.
      t0 = trails[0]; l0 = leads[0]; r0 = rxv_cnt[0]; b0 = rdy_bad[0];
      start(8'hA5, "a5");
      wait_idle("a5");
      check_eq("a5_mosi_seq", 32'(bits[0]), 32'hA5);
      check_eq("a5_leads",    32'(leads[0] - l0), 8);
      check_eq("a5_trails",   32'(trails[0] - t0), 8);
      check_eq("a5_rxd",      32'(rxd_a), RX ? 32'hA5 : 32'h0);
      check_eq("a5_rxv_cnt",  32'(rxv_cnt[0] - r0), RX ? 1 : 0);
      // one DRAIN cycle while the edge flag is seen, then two HOLD cycles
      check_eq("a5_cs_tail",  32'(tail_lo[0]), 3);
      check_eq("a5_ready_busy", 32'(rdy_bad[0] - b0), 0);
      check_eq("a5_sclk_en_off", 32'(en[0]), 0);

      // 0x01: LSB-first lane must emit 1 then seven zeros; its MISO is tied high.
      r1 = rxv_cnt[1];
      start(8'h01, "x01");
      wait_idle("x01");
      check_eq("x01_msb_seq", 32'(bits[0]), 32'h01);
      check_eq("x01_lsb_seq", 32'(bits[1]), 32'h80);
      check_eq("x01_lsb_rxd", 32'(rxd_b), RX ? 32'hFF : 32'h0);
      check_eq("x01_lsb_rxv", 32'(rxv_cnt[1] - r1), RX ? 1 : 0);

      // 0xFF with MISO held high (not looped).
      loop_a = 1'b0; miso_fix_a = 1'b1;
      t0 = trails[0]; r0 = rxv_cnt[0];
      start(8'hFF, "ff");
      wait_idle("ff");
      check_eq("ff_mosi_seq", 32'(bits[0]), 32'hFF);
      check_eq("ff_trails",   32'(trails[0] - t0), 8);
      check_eq("ff_cs_tail",  32'(tail_lo[0]), 3);
      check_eq("ff_rxd",      32'(rxd_a), RX ? 32'hFF : 32'h0);
      check_eq("ff_rxv_cnt",  32'(rxv_cnt[0] - r0), RX ? 1 : 0);
      loop_a = 1'b1; miso_fix_a = 1'b0;

      // Abort with reset after the third trailing edge.
      t0 = trails[0]; r0 = rxv_cnt[0];
      start(8'h5A, "abort");
      k = 0;
      while ((trails[0] - t0) < 3 && k < 200) begin
         @(posedge clk);
         k++;
      end
      check_eq("abort_reach3", 32'(k < 200), 1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_eq("abort_cs_n",    32'(cs_n[0]), 1);
      check_eq("abort_sclk_en", 32'(en[0]),   0);
      check_eq("abort_busy",    32'(busy[0]), 0);
      rst = 1'b0;
      k = 0;
      while (run !== 2'b00 && k < 100) begin
         @(negedge clk);
         k++;
      end
      check_eq("abort_div_idle", 32'(k < 100), 1);
      repeat (3) @(negedge clk);
      check_eq("abort_no_rxv", 32'(rxv_cnt[0] - r0), 0);
      check_eq("abort_ready",  32'(ready[0]), 1);

      r0 = rxv_cnt[0];
      start(8'h3C, "x3c");
      wait_idle("x3c");
      check_eq("x3c_mosi_seq", 32'(bits[0]), 32'h3C);
      check_eq("x3c_rxd",      32'(rxd_a), RX ? 32'h3C : 32'h0);
      check_eq("x3c_rxv_cnt",  32'(rxv_cnt[0] - r0), RX ? 1 : 0);

      // valid held high: 0x11, then 0x22 presented while busy.
      r0 = rxv_cnt[0]; b0 = rdy_bad[0];
      @(negedge clk);
      valid = 1'b1;
      data  = 8'h11;
      @(posedge clk);
      @(negedge clk);
      data  = 8'h22;
      k = 0;
      while (cs_n[0] !== 1'b1 && k < 300) begin
         @(negedge clk);
         k++;
      end
      check_eq("hold_first_done", 32'(k < 300), 1);
      check_eq("hold_first_seq",  32'(bits[0]), 32'h11);
      check_eq("hold_first_rxd",  32'(rxd_a), RX ? 32'h11 : 32'h0);
      gap = 0;
      while (cs_n[0] === 1'b1 && gap < 50) begin
         gap++;
         @(negedge clk);
      end
      valid = 1'b0;
      data  = 8'h00;
      check_eq("hold_gap_ge1",   32'(gap >= 1 && gap < 50), 1);
      check_eq("hold_second_acc", 32'(busy[0]), 1);
      wait_idle("hold_second");
      check_eq("hold_second_seq", 32'(bits[0]), 32'h22);
      check_eq("hold_second_rxd", 32'(rxd_a), RX ? 32'h22 : 32'h0);
      check_eq("hold_rxv_cnt",    32'(rxv_cnt[0] - r0), RX ? 2 : 0);
      check_eq("hold_ready_busy", 32'(rdy_bad[0] - b0), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/spi_shift.md
SPI_SHIFT -- requirements
Module: spi_shift

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving bits per transfer (legal range 2..32).
REQ-002 SHALL have parameter IDLE_HIGH, default 1, giving the SCLK idle level; it SHALL match the paired clock divider.
REQ-003 SHALL have parameter MSB_FIRST, default 1; 1 = MSB shifted first, 0 = LSB first.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk_i  in  1  system clock; rst_i  in  1  synchronous active-high reset.
REQ-005 SHALL have valid_i  in  1  transfer request.
REQ-006 SHALL have ready_o  out  1  transfer accepted when valid_i && ready_o.
REQ-007 SHALL have data_i  in  DATA_WIDTH  transmit word.
REQ-008 SHALL have sclk_i  in  1  divided clock from the divider, in the clk_i domain.
REQ-009 SHALL have sclk_en_o  out  1  enable to the divider.
REQ-010 SHALL have cs_n_o  out  1  chip select, active low.
REQ-011 SHALL have mosi_o  out  1  serial data out.
REQ-012 SHALL have miso_i  in  1  serial data in.
REQ-013 SHALL have rx_valid_o  out  1  one-cycle strobe marking rx_data_o valid.
REQ-014 SHALL have rx_data_o  out  DATA_WIDTH  received word.
REQ-015 SHALL have busy_o  out  1  high whenever the state is not IDLE.

Function
REQ-016 SHALL register sclk_i once and flag a leading edge (level leaving IDLE_HIGH) and a trailing edge (level returning to IDLE_HIGH), each one cycle after the sclk_i change.
REQ-017 SHALL implement the states IDLE, SETUP, SHIFT, DRAIN and HOLD, one-hot encoded.
REQ-018 In IDLE: ready_o=1; on handshake, latch data_i, drive cs_n_o=0, load the first bit onto mosi_o, load bit counter=0 and go to SETUP.
REQ-019 SETUP SHALL last exactly 1 cycle, then assert sclk_en_o and go to SHIFT.
REQ-020 In SHIFT: on each trailing edge, sample miso_i into the receive shift register and increment the bit counter; on each leading edge after the first, shift the next tx bit onto mosi_o.
REQ-021 On the trailing edge that brings the counter to DATA_WIDTH-1, SHALL deassert sclk_en_o in the next cycle and go to DRAIN.
REQ-022 In DRAIN: on the final trailing edge (counter = DATA_WIDTH), SHALL pulse rx_valid_o for 1 cycle with the complete word and go to HOLD.
REQ-023 HOLD SHALL keep cs_n_o=0 for 2 cycles, then drive cs_n_o=1 and return to IDLE.
REQ-024 ready_o SHALL be 0 in every state except IDLE; there SHALL be no back-to-back transfer without passing through IDLE (minimum 1 cycle with cs_n_o high).
REQ-025 mosi_o SHALL stay constant between leading edges; edges seen in IDLE or HOLD SHALL be ignored.
REQ-026 valid_i or data_i changing while busy_o=1 SHALL have no effect.
REQ-027 The bit counter SHALL be $clog2(DATA_WIDTH+1) wide and SHALL NOT wrap within a transfer.
REQ-028 SHALL operate correctly with a divider ratio of at least 4; smaller ratios are unsupported.

Reset
REQ-029 While rst_i=1 at a clk_i edge: state=IDLE, cs_n_o=1, sclk_en_o=0, mosi_o=0, rx_valid_o=0, rx_data_o=0, busy_o=0, ready_o=0, counter=0.
REQ-030 ready_o SHALL rise in the first cycle after rst_i deasserts.
REQ-031 Reset mid-transfer SHALL abort immediately, with no rx_valid_o pulse; the divider finishes its own cooldown independently.

Configuration
REQ-032 Macro SPI_SHIFT_RX_EN defined: receive path (REQ-020 sampling, REQ-022 strobe) SHALL be present.
REQ-033 Macro SPI_SHIFT_RX_EN undefined: miso_i SHALL be ignored, rx_data_o tied 0, rx_valid_o tied 0; all other timing SHALL be unchanged, including the DRAIN/HOLD sequence.

Structure
REQ-034 Package spi_pkg SHALL hold the state encoding constants, the default DATA_WIDTH and the minimum divider ratio constant.
REQ-035 Edge detection SHALL be a sub-module sclk_edge_detect (inputs: clock, reset, level, IDLE_HIGH parameter; outputs: leading, trailing).

Verification
REQ-036 Divider ratio 8, DATA_WIDTH=8, MSB_FIRST=1, data_i=0xA5, miso looped to mosi -> mosi_o sequence 1,0,1,0,0,1,0,1; rx_data_o=0xA5 with one rx_valid_o pulse.
REQ-037 MSB_FIRST=0, data_i=0x01, miso_i held 1 -> first mosi_o bit=1, then seven bits=0; rx_data_o=0xFF.
REQ-038 Transfer in progress, then count SCLK cycles -> exactly 8 leading and 8 trailing edges; cs_n_o low 2 cycles past the last trailing edge; ready_o=0 throughout.
REQ-039 rst_i pulsed after the 3rd trailing edge -> next cycle cs_n_o=1, sclk_en_o=0, no rx_valid_o; a following transfer of 0x3C completes correctly.
REQ-040 valid_i held high continuously with data 0x11 then 0x22 -> two transfers separated by at least 1 cycle of cs_n_o=1; 0x22 is sampled only at the second handshake.
REQ-041 Build without SPI_SHIFT_RX_EN, data_i=0xFF, miso_i=1 -> rx_valid_o never asserts; rx_data_o=0; mosi_o timing identical to REQ-036.
